// File: rtl/branch_update_scheduler.sv
// Queues resolved branches and schedules predictor-table updates on the shared
// table port, forcing the port away from fetch lookups after a starvation limit.
module branch_update_scheduler #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Resolve_valid,
   input  logic [31:0] Resolve_pc,
   input  logic [31:0] Resolve_target,
   input  logic        Resolve_taken,
   input  logic        Global_correct,
   input  logic        Local_correct,
   input  logic        Lookup_req,
   input  logic        Upd_ready,
   output logic        Upd_valid,
   output logic [31:0] Upd_pc,
   output logic [31:0] Upd_target,
   output logic        Upd_taken,
   output logic        Upd_meta_en,
   output logic        Upd_meta_global,
   output logic        Lookup_stall,
   output logic        Full,
   output logic [7:0]  Drop_count
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic        gc;
      logic        lc;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_FORCE} state_t;

   state_t        r_state;
   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve;
   logic [7:0]    r_drop;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   entry_t        w_head;

   assign w_full       = (r_count == CW'(DEPTH));
   assign Upd_valid    = (r_state == ST_ISSUE) || (r_state == ST_FORCE);
   assign Lookup_stall = (r_state == ST_FORCE);
   assign w_pop        = Upd_valid && Upd_ready;
   // A full queue still accepts a resolution when the head leaves on the same edge.
   assign w_push       = Resolve_valid && (!w_full || w_pop);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + CW'(1);
      else if (!w_push && w_pop)
         w_count_next = r_count - CW'(1);
   end

   assign w_head          = r_mem[r_head];
   assign Upd_pc          = w_head.pc;
   assign Upd_target      = w_head.target;
   assign Upd_taken       = w_head.taken;
   assign Upd_meta_en     = w_head.gc ^ w_head.lc;
   assign Upd_meta_global = w_head.gc;
   assign Full            = w_full;
   assign Drop_count      = r_drop;

   // Storage is cleared on reset so the head-driven outputs read zero while in reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_drop  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= '{pc: Resolve_pc, target: Resolve_target,
                               taken: Resolve_taken, gc: Global_correct,
                               lc: Local_correct};
            r_tail <= r_tail + AW'(1);
         end
         if (w_pop)
            r_head <= r_head + AW'(1);
         r_count <= w_count_next;
         if (Resolve_valid && w_full && !w_pop && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= ST_IDLE;
         r_starve <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_count_next != '0)
                  r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!Lookup_req) begin
                  r_state <= ST_ISSUE;
               end else begin
                  r_starve <= r_starve + SW'(1);
                  if ((r_starve + SW'(1)) == SW'(STARVE_LIMIT - 1))
                     r_state <= ST_FORCE;
               end
            end
            ST_ISSUE, ST_FORCE: begin
               if (Upd_ready) begin
                  r_starve <= '0;
                  r_state  <= (w_count_next != '0) ? ST_WAIT : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_branch_update_scheduler.sv
// Directed bench for branch_update_scheduler: single-entry vector table plus
// hand-written full/overflow, starvation, wrap and reset sequences.
module tb_branch_update_scheduler;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        Resolve_valid;
   logic [31:0] Resolve_pc;
   logic [31:0] Resolve_target;
   logic        Resolve_taken;
   logic        Global_correct;
   logic        Local_correct;
   logic        Lookup_req;
   logic        Upd_ready;
   logic        Upd_valid;
   logic [31:0] Upd_pc;
   logic [31:0] Upd_target;
   logic        Upd_taken;
   logic        Upd_meta_en;
   logic        Upd_meta_global;
   logic        Lookup_stall;
   logic        Full;
   logic [7:0]  Drop_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] got[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
      logic        gc;
      logic        lc;
      logic        exp_en;
      logic        exp_mg;
   } vec_t;
   vec_t vecs[4];

   branch_update_scheduler #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .Resolve_valid(Resolve_valid), .Resolve_pc(Resolve_pc),
      .Resolve_target(Resolve_target), .Resolve_taken(Resolve_taken),
      .Global_correct(Global_correct), .Local_correct(Local_correct),
      .Lookup_req(Lookup_req), .Upd_ready(Upd_ready),
      .Upd_valid(Upd_valid), .Upd_pc(Upd_pc), .Upd_target(Upd_target),
      .Upd_taken(Upd_taken), .Upd_meta_en(Upd_meta_en),
      .Upd_meta_global(Upd_meta_global), .Lookup_stall(Lookup_stall),
      .Full(Full), .Drop_count(Drop_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      Resolve_valid  = 1'b1;
      Resolve_pc     = pc;
      Resolve_target = pc + 32'h100;
      Resolve_taken  = 1'b1;
      Global_correct = 1'b1;
      Local_correct  = 1'b1;
      step();
      Resolve_valid  = 1'b0;
   endtask

   // Records the head pc for each cycle an update is presented; Upd_ready must be 1.
   task automatic drain(input int unsigned cycles);
      got.delete();
      for (int unsigned c = 0; c < cycles; c++) begin
         if (Upd_valid === 1'b1)
            got.push_back(Upd_pc);
         step();
      end
   endtask

   task automatic check_order(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input int n);
      logic [31:0] exp [4];
      exp = '{e0, e1, e2, e3};
      check({name, "_count"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n; i++)
         check({name, "_order"}, (i < got.size()) ? got[i] : 32'hx, exp[i]);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, 32'(Upd_valid), 32'd0);
      check({name, "_stall"}, 32'(Lookup_stall), 32'd0);
      check({name, "_full"}, 32'(Full), 32'd0);
      check({name, "_drop"}, 32'(Drop_count), 32'd0);
      check({name, "_meta_en"}, 32'(Upd_meta_en), 32'd0);
      check({name, "_meta_gl"}, 32'(Upd_meta_global), 32'd0);
      check({name, "_pc"}, Upd_pc, 32'd0);
      check({name, "_tgt"}, Upd_target, 32'd0);
      check({name, "_taken"}, 32'(Upd_taken), 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0040, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      RESET = 1'b0;
      Resolve_valid = 1'b0; Resolve_pc = '0; Resolve_target = '0; Resolve_taken = 1'b0;
      Global_correct = 1'b0; Local_correct = 1'b0; Lookup_req = 1'b0; Upd_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_all_zero("reset");
      @(negedge CLK);
      RESET = 1'b1;
      step();

      // Single-entry transactions: latency, data and meta training bits.
      Upd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Resolve_valid  = 1'b1;
         Resolve_pc     = vecs[i].pc;
         Resolve_target = vecs[i].tgt;
         Resolve_taken  = vecs[i].taken;
         Global_correct = vecs[i].gc;
         Local_correct  = vecs[i].lc;
         step();
         Resolve_valid = 1'b0;
         check("vec_wait_valid", 32'(Upd_valid), 32'd0);
         step();
         check("vec_valid", 32'(Upd_valid), 32'd1);
         check("vec_pc", Upd_pc, vecs[i].pc);
         check("vec_tgt", Upd_target, vecs[i].tgt);
         check("vec_taken", 32'(Upd_taken), 32'(vecs[i].taken));
         check("vec_meta_en", 32'(Upd_meta_en), 32'(vecs[i].exp_en));
         check("vec_meta_gl", 32'(Upd_meta_global), 32'(vecs[i].exp_mg));
         step();
         check("vec_idle_valid", 32'(Upd_valid), 32'd0);
         check("vec_idle_full", 32'(Full), 32'd0);
         step();
         check("vec_stay_idle", 32'(Upd_valid), 32'd0);
      end

      // Fill, overflow drop, then FIFO-order drain.
      Upd_ready = 1'b0;
      push(32'hA0); push(32'hB0); push(32'hC0); push(32'hD0);
      check("fill_full", 32'(Full), 32'd1);
      check("fill_drop0", 32'(Drop_count), 32'd0);
      push(32'hE0);
      check("ovf_full", 32'(Full), 32'd1);
      check("ovf_drop1", 32'(Drop_count), 32'd1);
      check("ovf_head", Upd_pc, 32'hA0);
      Upd_ready = 1'b1;
      drain(12);
      check_order("ovf_drain", 32'hA0, 32'hB0, 32'hC0, 32'hD0, 4);
      check("ovf_empty", 32'(Full), 32'd0);
      check("ovf_drop_kept", 32'(Drop_count), 32'd1);

      // Starvation: lookup held high forces the port on the 8th WAIT-relative cycle.
      Upd_ready  = 1'b0;
      Lookup_req = 1'b1;
      push(32'h5500);
      for (int k = 1; k <= 7; k++) begin
         check("starve_nostall", 32'(Lookup_stall), 32'd0);
         check("starve_novalid", 32'(Upd_valid), 32'd0);
         step();
      end
      check("force_stall", 32'(Lookup_stall), 32'd1);
      check("force_valid", 32'(Upd_valid), 32'd1);
      check("force_pc", Upd_pc, 32'h5500);
      step();
      check("force_hold", 32'(Lookup_stall), 32'd1);
      Upd_ready = 1'b1;
      step();
      check("force_release_stall", 32'(Lookup_stall), 32'd0);
      check("force_release_valid", 32'(Upd_valid), 32'd0);
      Lookup_req = 1'b0;

      // Full queue with simultaneous push and pop across the tail wrap.
      Upd_ready = 1'b0;
      push(32'h100); push(32'h200); push(32'h300); push(32'h400);
      check("wrap_full", 32'(Full), 32'd1);
      Upd_ready = 1'b1;
      push(32'h500);
      check("wrap_full_kept", 32'(Full), 32'd1);
      check("wrap_drop_kept", 32'(Drop_count), 32'd1);
      drain(12);
      check_order("wrap_drain", 32'h200, 32'h300, 32'h400, 32'h500, 4);
      check("wrap_empty", 32'(Full), 32'd0);

      // Reset mid-issue with three entries queued.
      Upd_ready = 1'b0;
      push(32'h700); push(32'h800); push(32'h900);
      check("pre_rst_valid", 32'(Upd_valid), 32'd1);
      RESET = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      @(negedge CLK);
      RESET = 1'b1;
      Upd_ready      = 1'b1;
      Resolve_valid  = 1'b1;
      Resolve_pc     = 32'hABC0;
      Resolve_target = 32'hDEF0;
      step();
      Resolve_valid = 1'b0;
      check("post_rst_wait", 32'(Upd_valid), 32'd0);
      step();
      check("post_rst_issue", 32'(Upd_valid), 32'd1);
      check("post_rst_tgt", Upd_target, 32'hDEF0);
      drain(8);
      check_order("post_rst", 32'hABC0, 32'h0, 32'h0, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
